// File: rtl/core_input_buf.sv
//------------------------------------------------------------------------------
// Module      : core_input_buf
// Description : Two-slot block buffer in front of one SHA256 core. Slot index
//               is the thread seq bit. Each slot holds DEPTH words of WIDTH
//               bits plus the block op. The upstream fan-out stage fills a
//               slot. The core then claims it, reads it and releases it.
//
// Ports       : CLK, reset         clock / synchronous active-high reset
//               wr_en, wr_addr,    word write into slot wr_seq
//               wr_seq, din
//               wr_blk_op,         block complete for slot wr_seq; op latched
//               set_input_ready
//               slot_empty[1:0]    slot is EMPTY (registered)
//               blk_ready[1:0]     slot is FULL (registered)
//               blk_op0, blk_op1   latched op per slot
//               rd_start, rd_done, claim / release slot rd_seq
//               rd_seq
//               rd_en, rd_addr     word read, dout valid one cycle later
//               dout
//               err                sticky illegal-event flag (only when
//                                  CORE_INPUT_BUF_ERR_EN is defined)
//
// Config      : CORE_INPUT_BUF_ERR_EN enables the err port.
//               BLK_OP_MSB sets the block-op width (default 1 -> 2 bits).
//
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef BLK_OP_MSB
`define BLK_OP_MSB 1
`endif

module core_input_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [3:0]           wr_addr,
    input  logic                 wr_seq,
    input  logic [WIDTH-1:0]     din,
    input  logic [`BLK_OP_MSB:0] wr_blk_op,
    input  logic                 set_input_ready,
    output logic [1:0]           slot_empty,
    output logic [1:0]           blk_ready,
    output logic [`BLK_OP_MSB:0] blk_op0,
    output logic [`BLK_OP_MSB:0] blk_op1,
    input  logic                 rd_start,
    input  logic                 rd_seq,
    input  logic                 rd_en,
    input  logic [3:0]           rd_addr,
    output logic [WIDTH-1:0]     dout,
    input  logic                 rd_done
`ifdef CORE_INPUT_BUF_ERR_EN
    ,
    output logic                 err
`endif
);

    localparam int c_mem_words = 2 * DEPTH;

    typedef enum logic [1:0] {
        c_st_empty   = 2'd0,
        c_st_filling = 2'd1,
        c_st_full    = 2'd2,
        c_st_reading = 2'd3
    } slot_state_t;

    slot_state_t      r_state     [2];
    slot_state_t      w_state_nxt [2];

    logic [WIDTH-1:0] r_mem [c_mem_words];

    logic [1:0]       w_wr_sel;
    logic [1:0]       w_rd_sel;
    logic             w_wr_ok;
    logic [1:0]       w_op_load;

    // One-hot slot selects for the write side and the read side.
    assign w_wr_sel = wr_seq ? 2'b10 : 2'b01;
    assign w_rd_sel = rd_seq ? 2'b10 : 2'b01;

    // Only EMPTY/FILLING slots accept data; FULL/READING slots are protected.
    assign w_wr_ok = (r_state[wr_seq] == c_st_empty) ||
                     (r_state[wr_seq] == c_st_filling);

    //--------------------------------------------------------------------------
    // Per-slot next-state logic. The two slots are fully independent. This
    // lets a write to one slot and a read claim/release on the other take
    // effect in the same cycle.
    //--------------------------------------------------------------------------
    always_comb begin
        w_op_load = 2'b00;
        for (int n = 0; n < 2; n++) begin
            w_state_nxt[n] = r_state[n];
            case (r_state[n])
                c_st_empty: begin
                    // A zero-word block goes straight to FULL.
                    if (set_input_ready && w_wr_sel[n]) begin
                        w_state_nxt[n] = c_st_full;
                        w_op_load[n]   = 1'b1;
                    end else if (wr_en && w_wr_sel[n]) begin
                        w_state_nxt[n] = c_st_filling;
                    end
                end
                c_st_filling: begin
                    if (set_input_ready && w_wr_sel[n]) begin
                        w_state_nxt[n] = c_st_full;
                        w_op_load[n]   = 1'b1;
                    end
                end
                c_st_full: begin
                    if (rd_start && w_rd_sel[n]) begin
                        w_state_nxt[n] = c_st_reading;
                    end
                end
                c_st_reading: begin
                    // rd_done wins; a same-cycle rd_start only sees EMPTY next cycle.
                    if (rd_done && w_rd_sel[n]) begin
                        w_state_nxt[n] = c_st_empty;
                    end
                end
                default: w_state_nxt[n] = c_st_empty;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // State and status registers. slot_empty/blk_ready are registered from the
    // next state, so they track the state register exactly.
    //--------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int n = 0; n < 2; n++) begin
                r_state[n] <= c_st_empty;
            end
            slot_empty <= 2'b11;
            blk_ready  <= 2'b00;
            blk_op0    <= '0;
            blk_op1    <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                r_state[n]    <= w_state_nxt[n];
                slot_empty[n] <= (w_state_nxt[n] == c_st_empty);
                blk_ready[n]  <= (w_state_nxt[n] == c_st_full);
            end
            if (w_op_load[0]) begin
                blk_op0 <= wr_blk_op;
            end
            if (w_op_load[1]) begin
                blk_op1 <= wr_blk_op;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Block storage. Contents survive reset; only the slot states are aborted.
    //--------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (wr_en && w_wr_ok) begin
            r_mem[{wr_seq, wr_addr}] <= din;
        end
    end

    // Registered read. There is no state check, and dout holds when idle.
    always_ff @(posedge CLK) begin
        if (reset) begin
            dout <= '0;
        end else if (rd_en) begin
            dout <= r_mem[{rd_seq, rd_addr}];
        end
    end

`ifdef CORE_INPUT_BUF_ERR_EN
    logic w_illegal;

    assign w_illegal = (wr_en    && !w_wr_ok) ||
                       (rd_start && (r_state[rd_seq] != c_st_full)) ||
                       (rd_done  && (r_state[rd_seq] != c_st_reading));

    always_ff @(posedge CLK) begin
        if (reset) begin
            err <= 1'b0;
        end else if (w_illegal) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire
